// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: display fetch has strict priority, writer goes through a 1-entry buffer.
// Optional VGA_FB_ARB_STATS_EN adds write/stall statistics counters.
module vga_fb_arbiter #(
   parameter int unsigned ADDR_W   = 17,
   parameter int unsigned DATA_W   = 12,
   parameter int unsigned MAX_WAIT = 64
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_rdata,
   output logic              disp_valid,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic              wr_starved,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
`ifdef VGA_FB_ARB_STATS_EN
   ,
   output logic [31:0]       stat_wr_cnt,
   output logic [31:0]       stat_stall_cnt
`endif
);

   localparam int unsigned CntW = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {StIdle, StRd, StWr} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [ADDR_W-1:0]   r_stage_addr;
   logic [DATA_W-1:0]   r_stage_data;
   logic                r_full;
   logic [ADDR_W-1:0]   r_buf_addr;
   logic [DATA_W-1:0]   r_buf_data;
   logic                r_ack;
   logic [1:0]          r_rv;
   logic [CntW-1:0]     r_wait;
   logic                w_issue;
   logic                w_stall;
   logic                w_accept;

   always_comb begin
      w_issue      = r_full && !disp_req;
      w_stall      = r_full && disp_req;
      // r_ack blocks a second capture of a request the writer has not yet dropped
      w_accept     = wr_req && !r_ack && (!r_full || w_issue);
      w_state_next = StIdle;
      if (disp_req) begin
         w_state_next = StRd;
      end else if (r_full) begin
         w_state_next = StWr;
      end
   end

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state      <= StIdle;
         r_stage_addr <= '0;
         r_stage_data <= '0;
         r_full       <= 1'b0;
         r_buf_addr   <= '0;
         r_buf_data   <= '0;
         r_ack        <= 1'b0;
         r_rv         <= '0;
         r_wait       <= '0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         mem_we       <= 1'b0;
         disp_valid   <= 1'b0;
         disp_rdata   <= '0;
      end else begin
         r_state      <= w_state_next;
         r_stage_addr <= disp_req ? disp_addr : r_buf_addr;
         r_stage_data <= r_buf_data;

         unique case (r_state)
            StRd: begin
               mem_addr <= r_stage_addr;
               mem_we   <= 1'b0;
            end
            StWr: begin
               mem_addr  <= r_stage_addr;
               mem_wdata <= r_stage_data;
               mem_we    <= 1'b1;
            end
            default: mem_we <= 1'b0;
         endcase

         // Two stages: RAM address register, then RAM output register
         r_rv       <= {r_rv[0], r_state == StRd};
         disp_valid <= r_rv[1];
         if (r_rv[1]) begin
            disp_rdata <= mem_rdata;
         end

         if (w_accept) begin
            r_full     <= 1'b1;
            r_buf_addr <= wr_addr;
            r_buf_data <= wr_data;
         end else if (w_issue) begin
            r_full <= 1'b0;
         end
         r_ack <= w_accept;

         if (w_issue) begin
            r_wait <= '0;
         end else if (w_stall && (r_wait != CntW'(MAX_WAIT))) begin
            r_wait <= r_wait + CntW'(1);
         end
      end
   end

   assign wr_ack     = r_ack;
   assign wr_starved = (r_wait == CntW'(MAX_WAIT));

`ifdef VGA_FB_ARB_STATS_EN
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         stat_wr_cnt    <= '0;
         stat_stall_cnt <= '0;
      end else begin
         if (r_state == StWr) begin
            stat_wr_cnt <= stat_wr_cnt + 32'd1;
         end
         if (w_stall) begin
            stat_stall_cnt <= stat_stall_cnt + 32'd1;
         end
      end
   end
`endif

endmodule
